// File: rtl/vga_digit_ctrl.sv
// Digit sequencer and frame-synchronous colour configuration for a VGA digit display.
// Debounced push-buttons latch switch slices into shadows that reach the outputs on frame_start.
module vga_digit_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int FRAMES_PER_DIGIT = 60
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       btnr,
    input  logic       btng,
    input  logic       btnb,
    input  logic [7:0] sw,
    input  logic       frame_start,
    input  logic       run,
    input  logic       step,
    output logic [3:0] digit,
    output logic [2:0] red_cfg,
    output logic [2:0] green_cfg,
    output logic [1:0] blue_cfg,
    output logic [2:0] cfg_ack
);

    // state  | meaning
    // S_HOLD | digit frozen; a step request advances it once at the next frame_start
    // S_RUN  | digit advances every FRAMES_PER_DIGIT frames
    typedef enum logic {
        S_HOLD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W = (FRAMES_PER_DIGIT > 1) ? $clog2(FRAMES_PER_DIGIT) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_DIGIT - 1);

    // Channel index 2 = red, 1 = green, 0 = blue throughout, matching cfg_ack.
    logic [2:0]      w_btn;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [DB_W-1:0] r_db_cnt [3];
    logic [2:0]      w_db_flip;
    logic [2:0]      w_rise;
    logic [2:0]      r_pend;
    logic [2:0]      w_grant;
    logic [2:0]      r_ack;

    logic [2:0]      r_sh_r;
    logic [2:0]      r_sh_g;
    logic [1:0]      r_sh_b;
    logic [2:0]      r_cfg_r;
    logic [2:0]      r_cfg_g;
    logic [1:0]      r_cfg_b;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FC_W-1:0] r_fc;
    logic            r_step_pend;
    logic [3:0]      r_digit;
    logic            w_fc_clr;
    logic            w_fc_inc;
    logic            w_step_set;
    logic            w_step_clr;
    logic            w_adv;

    assign w_btn = {btnr, btng, btnb};

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_db_flip = 3'b000;
        for (int i = 0; i < 3; i++) begin
            w_db_flip[i] = (r_sync2[i] != r_db[i]) && (r_db_cnt[i] == DB_LAST);
        end
        w_rise = w_db_flip & r_sync2;
    end

    // Counter measures how long the synchronised level has disagreed with the accepted one.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_db <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_flip[i]) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_grant = 3'b000;
        if (r_pend[2]) begin
            w_grant = 3'b100;
        end else if (r_pend[1]) begin
            w_grant = 3'b010;
        end else if (r_pend[0]) begin
            w_grant = 3'b001;
        end
    end

    // A rise landing on its own grant cycle re-arms pending for a second write.
    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_pend <= 3'b000;
            r_ack  <= 3'b000;
            r_sh_r <= 3'b111;
            r_sh_g <= 3'b000;
            r_sh_b <= 2'b00;
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_rise;
            r_ack  <= w_grant;
            if (w_grant[2]) begin
                r_sh_r <= sw[2:0];
            end
            if (w_grant[1]) begin
                r_sh_g <= sw[5:3];
            end
            if (w_grant[0]) begin
                r_sh_b <= sw[7:6];
            end
        end
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_cfg_r <= 3'b111;
            r_cfg_g <= 3'b000;
            r_cfg_b <= 2'b00;
        end else if (frame_start) begin
            r_cfg_r <= r_sh_r;
            r_cfg_g <= r_sh_g;
            r_cfg_b <= r_sh_b;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fc_clr    = 1'b0;
        w_fc_inc    = 1'b0;
        w_step_set  = 1'b0;
        w_step_clr  = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (run) begin
                    w_state_nxt = S_RUN;
                    w_fc_clr    = 1'b1;
                    w_step_clr  = 1'b1;
                end else begin
                    if (frame_start && r_step_pend) begin
                        w_adv      = 1'b1;
                        w_step_clr = 1'b1;
                    end
                    if (step) begin
                        w_step_set = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!run) begin
                    w_state_nxt = S_HOLD;
                end else if (frame_start) begin
                    if (r_fc == FC_LAST) begin
                        w_fc_clr = 1'b1;
                        w_adv    = 1'b1;
                    end else begin
                        w_fc_inc = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state     <= S_HOLD;
            r_fc        <= '0;
            r_step_pend <= 1'b0;
            r_digit     <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fc_clr) begin
                r_fc <= '0;
            end else if (w_fc_inc) begin
                r_fc <= r_fc + 1'b1;
            end
            // A step arriving with the consuming frame_start queues the next advance.
            if (w_step_set) begin
                r_step_pend <= 1'b1;
            end else if (w_step_clr) begin
                r_step_pend <= 1'b0;
            end
            if (w_adv) begin
                r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
            end
        end
    end

    assign digit     = r_digit;
    assign red_cfg   = r_cfg_r;
    assign green_cfg = r_cfg_g;
    assign blue_cfg  = r_cfg_b;
    assign cfg_ack   = r_ack;

endmodule

// File: tb/tb_vga_digit_ctrl.sv
// Self-checking bench for vga_digit_ctrl with small debounce and frame parameters.
// Expected colours and digits come from a frame/press-level model, not from the DUT.
module tb_vga_digit_ctrl;

    localparam int DB  = 4;
    localparam int FPD = 2;

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       btnr = 1'b0, btng = 1'b0, btnb = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       frame_start = 1'b0, run = 1'b0, step = 1'b0;
    logic [3:0] digit;
    logic [2:0] red_cfg, green_cfg, cfg_ack;
    logic [1:0] blue_cfg;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // model state
    logic [2:0] m_sh_r = 3'd7, m_sh_g = 3'd0;
    logic [1:0] m_sh_b = 2'd0;
    logic [2:0] m_r = 3'd7, m_g = 3'd0;
    logic [1:0] m_b = 2'd0;
    int         m_digit = 0;

    logic [2:0] acks[$];
    int         ack_cyc[$];

    vga_digit_ctrl #(.DEBOUNCE_CYCLES(DB), .FRAMES_PER_DIGIT(FPD)) dut (
        .dclk(dclk), .clr_n(clr_n), .btnr(btnr), .btng(btng), .btnb(btnb), .sw(sw),
        .frame_start(frame_start), .run(run), .step(step), .digit(digit),
        .red_cfg(red_cfg), .green_cfg(green_cfg), .blue_cfg(blue_cfg), .cfg_ack(cfg_ack)
    );

    always #5 dclk = ~dclk;

    task automatic tick();
        @(posedge dclk);
        #1;
        cyc++;
    endtask

    task automatic collect(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            if (cfg_ack !== 3'b000) begin
                acks.push_back(cfg_ack);
                ack_cyc.push_back(cyc);
            end
        end
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_r = m_sh_r;
        m_g = m_sh_g;
        m_b = m_sh_b;
    endtask

    task automatic model_press(input logic [2:0] mask, input logic [7:0] s);
        if (mask[2]) m_sh_r = s[2:0];
        if (mask[1]) m_sh_g = s[5:3];
        if (mask[0]) m_sh_b = s[7:6];
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        #23;
        n_total++;
        if ({digit, red_cfg, green_cfg, blue_cfg, cfg_ack} !== {4'd0, 3'd7, 3'd0, 2'd0, 3'd0})
            $display("FAIL reset_outputs: got d=%0d r=%0d g=%0d b=%0d ack=%b expected d=0 r=7 g=0 b=0 ack=000",
                     digit, red_cfg, green_cfg, blue_cfg, cfg_ack);
        else n_pass++;
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_single_red();
        int n100 = 0;
        int nother = 0;
        int early = 0;
        sw = 8'hFF;
        btnr = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c == 10) btnr = 1'b0;
            tick();
            if (cfg_ack === 3'b100) n100++;
            else if (cfg_ack !== 3'b000) nother++;
            if (red_cfg !== 3'd7) early++;
        end
        model_press(3'b100, sw);
        n_total++;
        if (n100 !== 1) $display("FAIL single_red_ack_count: got %0d expected 1", n100);
        else n_pass++;
        n_total++;
        if (nother !== 0) $display("FAIL single_red_other_ack: got %0d expected 0", nother);
        else n_pass++;
        n_total++;
        if (early !== 0) $display("FAIL single_red_early_change: got %0d cycles expected 0", early);
        else n_pass++;
        pulse_frame();
        n_total++;
        if ({red_cfg, green_cfg, blue_cfg} !== {m_r, m_g, m_b})
            $display("FAIL single_red_frame: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                     red_cfg, green_cfg, blue_cfg, m_r, m_g, m_b);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        acks.delete();
        ack_cyc.delete();
        sw = 8'b10_011_101;
        {btnr, btng, btnb} = 3'b111;
        collect(14);
        {btnr, btng, btnb} = 3'b000;
        collect(12);
        model_press(3'b111, sw);
        n_total++;
        if (acks.size() !== 3) $display("FAIL simul_ack_count: got %0d expected 3", acks.size());
        else n_pass++;
        if (acks.size() == 3) begin
            n_total++;
            if ({acks[0], acks[1], acks[2]} !== {3'b100, 3'b010, 3'b001})
                $display("FAIL simul_ack_order: got %b %b %b expected 100 010 001", acks[0], acks[1], acks[2]);
            else n_pass++;
            n_total++;
            if (ack_cyc[1] - ack_cyc[0] !== 1 || ack_cyc[2] - ack_cyc[1] !== 1)
                $display("FAIL simul_ack_consecutive: got cycles %0d %0d %0d expected consecutive",
                         ack_cyc[0], ack_cyc[1], ack_cyc[2]);
            else n_pass++;
        end
        n_total++;
        if ({red_cfg, green_cfg, blue_cfg} !== {m_r, m_g, m_b})
            $display("FAIL simul_before_frame: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                     red_cfg, green_cfg, blue_cfg, m_r, m_g, m_b);
        else n_pass++;
        pulse_frame();
        n_total++;
        if ({red_cfg, green_cfg, blue_cfg} !== {3'd5, 3'd3, 2'd2})
            $display("FAIL simul_after_frame: got r=%0d g=%0d b=%0d expected r=5 g=3 b=2",
                     red_cfg, green_cfg, blue_cfg);
        else n_pass++;
    endtask

    task automatic test_bounce();
        acks.delete();
        ack_cyc.delete();
        sw = 8'h00;
        for (int c = 0; c < 20; c++) begin
            btng = ((c / 2) % 2) == 0;
            collect(1);
        end
        btng = 1'b0;
        collect(12);
        n_total++;
        if (acks.size() !== 0) $display("FAIL bounce_ack: got %0d acks expected 0", acks.size());
        else n_pass++;
        pulse_frame();
        n_total++;
        if (green_cfg !== m_g) $display("FAIL bounce_green: got %0d expected %0d", green_cfg, m_g);
        else n_pass++;
    endtask

    task automatic test_random_colour();
        for (int r = 0; r < 8; r++) begin
            logic [2:0] mask;
            logic [2:0] expq[$];
            mask = 3'($urandom_range(1, 7));
            sw = 8'($urandom);
            acks.delete();
            ack_cyc.delete();
            for (int b = 2; b >= 0; b--) if (mask[b]) expq.push_back(3'b001 << b);
            {btnr, btng, btnb} = mask;
            collect(10);
            {btnr, btng, btnb} = 3'b000;
            collect(10);
            model_press(mask, sw);
            n_total++;
            if (acks.size() !== expq.size() || acks != expq)
                $display("FAIL rand_colour_acks: round %0d got %0d acks first=%b expected %0d acks first=%b",
                         r, acks.size(), (acks.size() > 0) ? acks[0] : 3'b000, expq.size(), expq[0]);
            else n_pass++;
            n_total++;
            if ({red_cfg, green_cfg, blue_cfg} !== {m_r, m_g, m_b})
                $display("FAIL rand_colour_hold: round %0d got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                         r, red_cfg, green_cfg, blue_cfg, m_r, m_g, m_b);
            else n_pass++;
            if ($urandom_range(0, 1) == 1) begin
                pulse_frame();
                n_total++;
                if ({red_cfg, green_cfg, blue_cfg} !== {m_r, m_g, m_b})
                    $display("FAIL rand_colour_frame: round %0d got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                             r, red_cfg, green_cfg, blue_cfg, m_r, m_g, m_b);
                else n_pass++;
            end
        end
        pulse_frame();
        tick();
    endtask

    task automatic test_run_sequence();
        int d0;
        d0 = m_digit;
        run = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 20; k++) begin
            n_total++;
            if (digit !== 4'((d0 + k / FPD) % 10))
                $display("FAIL run_seq: frame %0d got %0d expected %0d", k, digit, (d0 + k / FPD) % 10);
            else n_pass++;
            pulse_frame();
            tick();
        end
        m_digit = (d0 + 20 / FPD) % 10;
        n_total++;
        if (digit !== 4'(m_digit)) $display("FAIL run_wrap: got %0d expected %0d", digit, m_digit);
        else n_pass++;
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_step();
        step = 1'b1; tick(); step = 1'b0; tick();
        pulse_frame(); tick();
        m_digit = (m_digit + 1) % 10;
        n_total++;
        if (digit !== 4'(m_digit)) $display("FAIL step_first: got %0d expected %0d", digit, m_digit);
        else n_pass++;
        pulse_frame(); tick();
        n_total++;
        if (digit !== 4'(m_digit)) $display("FAIL step_second: got %0d expected %0d", digit, m_digit);
        else n_pass++;
        run = 1'b1; tick(); tick();
        step = 1'b1; tick(); step = 1'b0; tick();
        run = 1'b0; tick(); tick();
        pulse_frame(); tick();
        n_total++;
        if (digit !== 4'(m_digit)) $display("FAIL step_in_run: got %0d expected %0d", digit, m_digit);
        else n_pass++;
        step = 1'b1; tick(); step = 1'b0; tick();
        run = 1'b1; tick(); tick();
        run = 1'b0; tick(); tick();
        pulse_frame(); tick();
        n_total++;
        if (digit !== 4'(m_digit)) $display("FAIL step_cleared_by_run: got %0d expected %0d", digit, m_digit);
        else n_pass++;
    endtask

    task automatic test_random_digit();
        for (int e = 0; e < 12; e++) begin
            if ($urandom_range(0, 1) == 1) begin
                int n;
                n = $urandom_range(0, 7);
                run = 1'b1; tick(); tick();
                for (int f = 0; f < n; f++) begin
                    pulse_frame();
                    tick();
                end
                run = 1'b0; tick(); tick();
                m_digit = (m_digit + n / FPD) % 10;
            end else begin
                int ns;
                int nf;
                ns = $urandom_range(0, 3);
                nf = $urandom_range(1, 3);
                for (int s = 0; s < ns; s++) begin
                    step = 1'b1; tick(); step = 1'b0; tick();
                end
                for (int f = 0; f < nf; f++) begin
                    pulse_frame();
                    tick();
                end
                if (ns > 0) m_digit = (m_digit + 1) % 10;
            end
            n_total++;
            if (digit !== 4'(m_digit)) $display("FAIL rand_digit: episode %0d got %0d expected %0d", e, digit, m_digit);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        while (m_digit != 7) begin
            step = 1'b1; tick(); step = 1'b0; tick();
            pulse_frame(); tick();
            m_digit = (m_digit + 1) % 10;
        end
        n_total++;
        if (digit !== 4'd7) $display("FAIL pre_reset_digit: got %0d expected 7", digit);
        else n_pass++;
        sw = 8'h00;
        btnr = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        #2;
        clr_n = 1'b0;
        #1;
        n_total++;
        if ({digit, red_cfg, green_cfg, blue_cfg, cfg_ack} !== {4'd0, 3'd7, 3'd0, 2'd0, 3'd0})
            $display("FAIL async_reset: got d=%0d r=%0d g=%0d b=%0d ack=%b expected d=0 r=7 g=0 b=0 ack=000",
                     digit, red_cfg, green_cfg, blue_cfg, cfg_ack);
        else n_pass++;
        m_digit = 0;
        m_sh_r = 3'd7; m_sh_g = 3'd0; m_sh_b = 2'd0;
        m_r = 3'd7; m_g = 3'd0; m_b = 2'd0;
        btnr = 1'b0;
        tick(); tick();
        clr_n = 1'b1;
        acks.delete();
        ack_cyc.delete();
        collect(20);
        n_total++;
        if (acks.size() !== 0) $display("FAIL post_reset_ack: got %0d acks expected 0", acks.size());
        else n_pass++;
        pulse_frame();
        n_total++;
        if ({red_cfg, green_cfg, blue_cfg} !== {m_r, m_g, m_b})
            $display("FAIL post_reset_colour: got r=%0d g=%0d b=%0d expected r=%0d g=%0d b=%0d",
                     red_cfg, green_cfg, blue_cfg, m_r, m_g, m_b);
        else n_pass++;
    endtask

    task automatic test_held_through_reset();
        sw = 8'h03;
        btnr = 1'b1;
        tick();
        clr_n = 1'b0;
        tick(); tick();
        clr_n = 1'b1;
        acks.delete();
        ack_cyc.delete();
        collect(12);
        btnr = 1'b0;
        collect(10);
        model_press(3'b100, sw);
        n_total++;
        if (acks.size() !== 1 || acks[0] !== 3'b100)
            $display("FAIL held_reset_ack: got %0d acks first=%b expected 1 ack 100",
                     acks.size(), (acks.size() > 0) ? acks[0] : 3'b000);
        else n_pass++;
        pulse_frame();
        n_total++;
        if (red_cfg !== m_r) $display("FAIL held_reset_red: got %0d expected %0d", red_cfg, m_r);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_red();
        test_simultaneous();
        test_bounce();
        test_random_colour();
        test_run_sequence();
        test_step();
        test_random_digit();
        test_reset_mid();
        test_held_through_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vga_digit_ctrl.md
VGA_DIGIT_CTRL -- requirements
Module: vga_digit_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, giving the consecutive stable cycles needed to accept a button level (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter FRAMES_PER_DIGIT, default 60, giving the frames shown per digit in auto mode.
REQ-003 The block SHALL have port dclk, input, 1 bit: the 25 MHz pixel clock, the only clock.
REQ-004 The block SHALL have port clr_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have ports btnr/btng/btnb, inputs, 1 bit each: raw asynchronous push-buttons selecting the red, green or blue colour write.
REQ-006 The block SHALL have port sw, input, 8 bits: colour source; [2:0] red, [5:3] green, [7:6] blue.
REQ-007 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse at the first cycle of each frame, synchronous to dclk.
REQ-008 The block SHALL have port run, input, 1 bit, synchronous: 1 = auto-advance digits, 0 = hold.
REQ-009 The block SHALL have port step, input, 1 bit, synchronous one-cycle pulse: request a single digit advance while holding.
REQ-010 The block SHALL have port digit, output, 4 bits: digit to display, 0..9.
REQ-011 The block SHALL have ports red_cfg (3), green_cfg (3), blue_cfg (2), outputs: active colour.
REQ-012 The block SHALL have port cfg_ack, output, 3 bits, [2]=r [1]=g [0]=b: one-cycle pulse per accepted colour write.

Function
REQ-013 Each button SHALL pass a 2-flop synchroniser, then a debouncer whose output changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce SHALL restart the count.
REQ-014 A debounced 0->1 edge SHALL set that channel's pending flag; release edges SHALL be ignored; a set flag stays set under further edges.
REQ-015 The arbiter SHALL grant at most one pending channel per cycle, fixed priority red > green > blue.
REQ-016 On a grant edge, the shadow register for that channel SHALL load its sw slice, its pending flag SHALL clear, and cfg_ack SHALL pulse high for exactly the next cycle.
REQ-017 An edge arriving in the same cycle as a grant for that channel SHALL re-set pending, giving a second grant.
REQ-018 On frame_start, red_cfg/green_cfg/blue_cfg SHALL load from the shadows; the outputs SHALL never change at any other time.
REQ-019 A shadow write coinciding with frame_start SHALL reach the outputs at the following frame_start.
REQ-020 The sequencer FSM SHALL have states HOLD and RUN: HOLD->RUN when run=1; RUN->HOLD when run=0; each transition takes one cycle.
REQ-021 Entering RUN SHALL clear the frame counter (width ceil(log2(FRAMES_PER_DIGIT))).
REQ-022 In RUN, each frame_start SHALL increment the frame counter; at FRAMES_PER_DIGIT-1 it SHALL wrap to 0 and digit SHALL advance.
REQ-023 In HOLD, a step pulse SHALL set a step-pending flag; the next frame_start SHALL advance digit once and clear the flag; the frame counter stays frozen.
REQ-024 A step pulse in RUN SHALL be ignored; a step-pending flag SHALL be cleared on HOLD->RUN.
REQ-025 A digit advance SHALL follow 0,1,...,9,0; digit SHALL never exceed 9.

Reset
REQ-026 When clr_n is low, every register SHALL clear asynchronously: digit=0, red_cfg=3'b111, green_cfg=0, blue_cfg=0, shadows equal to those values, cfg_ack=0, pending=0, debounced levels=0, counters=0, FSM=HOLD.
REQ-027 Reset mid-debounce or mid-grant SHALL discard the request; a button still held at release of reset SHALL be accepted after DEBOUNCE_CYCLES as a new edge.

Verification (DEBOUNCE_CYCLES=4, FRAMES_PER_DIGIT=2)
REQ-028 The bench SHALL check: sw=8'hFF, btnr high 10 cycles -> cfg_ack=3'b100 for exactly one cycle, red_cfg stays 3'b111 until the next frame_start, then 3'b111; green/blue unchanged.
REQ-029 The bench SHALL check: btnr/btng/btnb pressed together with sw=8'b10_011_101 -> cfg_ack 100, 010, 001 on three consecutive cycles; after frame_start red=5, green=3, blue=2.
REQ-030 The bench SHALL check: btng toggled every 2 cycles for 20 cycles, then low -> no cfg_ack, green_cfg unchanged.
REQ-031 The bench SHALL check: run=1, 20 frame_start pulses -> digit sequence 0,0,1,1,...,9,9 then 0 (wrap).
REQ-032 The bench SHALL check: run=0, step pulse, then two frame_start pulses -> digit advances by exactly 1 at the first one; step with run=1 -> no extra advance.
REQ-033 The bench SHALL check: clr_n low asynchronously while digit=7 and red pending -> all outputs take reset values at once; no cfg_ack after release.
